rvmyth_mem_arbiter: RTL

Shares one single-port, word-wide SRAM between the rvmyth instruction-fetch port and data (load/store) port, replacing the separate instruction and data arrays with one unified memory. Each cycle it grants at most one requester. Returned read data is routed to the requester that issued the read. Data accesses have fixed priority because the MEM stage holds the older instruction. A starvation counter guarantees that fetch makes forward progress.

---
 rtl/rvmyth_pkg.sv | 13 +
 rtl/rvmyth_starve_ctr.sv | 40 ++++
 rtl/rvmyth_mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rvmyth_pkg.sv
// Shared types and constants for the rvmyth unified-memory subsystem.
package rvmyth_pkg;

  localparam int XLEN = 32;

  // Which port, if any, owns the read data that arrives from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/rvmyth_starve_ctr.sv
// Saturating counter: clr wins over inc, holds at MAX, at_max flags the ceiling.
// Registered count, no backpressure; reusable wherever a master needs a starvation bound.
module rvmyth_starve_ctr #(
  parameter int MAX   = 3,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/rvmyth_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port SRAM; grant is same-cycle combinational,
// read data returns one cycle after the grant edge, and the losing port simply holds its request.
module rvmyth_mem_arbiter
  import rvmyth_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  rd_owner_t         rd_owner_q;
  rd_owner_t         rd_owner_d;
  logic              fetch_wins;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_at_max;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] if_waddr;
  logic [ADDR_W-1:0] d_waddr;
  logic              owner_if;
  logic              owner_d;
  logic              unused_ok;

  // Byte offset and high bits are dropped so addresses wrap modulo the array size.
  assign if_waddr = if_addr[ADDR_W+1:2];
  assign d_waddr  = d_addr[ADDR_W+1:2];

  // Data normally wins (older instruction in MEM); fetch is forced through once starved.
  always_comb begin
    fetch_wins = if_req & (~d_req | starve_at_max);
    if_gnt_c   = rst_n & fetch_wins;
    d_gnt_c    = rst_n & d_req & ~fetch_wins;
  end

  assign starve_inc = d_gnt_c & if_req;
  assign starve_clr = if_gnt_c | ~if_req;

  rvmyth_starve_ctr #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .count  (starve_cnt),
    .at_max (starve_at_max)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt_c) begin
      mem_en   = 1'b1;
      mem_addr = if_waddr;
    end else if (d_gnt_c) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_waddr;
      mem_wdata = d_wdata;
    end
  end

  assign if_gnt = if_gnt_c;
  assign d_gnt  = d_gnt_c;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (if_gnt_c) begin
      rd_owner_d = OWN_IF;
    end else if (d_gnt_c && !d_we) begin
      rd_owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gating with rst_n drops a read that was in flight when reset arrived.
  assign owner_if = rst_n & (rd_owner_q == OWN_IF);
  assign owner_d  = rst_n & (rd_owner_q == OWN_D);

  assign if_rvalid = owner_if;
  assign d_rvalid  = owner_d;
  assign if_rdata  = owner_if ? mem_rdata : '0;
  assign d_rdata   = owner_d  ? mem_rdata : '0;

  assign unused_ok = ^{if_addr[XLEN-1:ADDR_W+2], if_addr[1:0],
                       d_addr[XLEN-1:ADDR_W+2], d_addr[1:0], starve_cnt};

endmodule
